// File: rtl/mat_assemble.sv
// Assembles a stream of 32-bit elements into an M x N matrix, double-buffered:
// a shifting fill buffer feeds the output register so input can continue while the output waits.
module mat_assemble #(
    parameter int unsigned M = 2,
    parameter int unsigned N = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    input_elem,
    input  logic                           input_elem_stb,
    output logic                           input_elem_ack,
    output logic [M-1:0][N-1:0][31:0]      output_mat,
    output logic                           output_mat_stb,
    input  logic                           output_mat_ack,
    output logic [$clog2(M*N+1)-1:0]       fill_count
);

    localparam int unsigned TOTAL = M * N;
    localparam int unsigned MW    = TOTAL * 32;
    localparam int unsigned CW    = $clog2(TOTAL + 1);
    localparam int unsigned RW    = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned CLW   = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        S_FILLING = 1'b0,
        S_FULL    = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [MW-1:0]    r_buf;
    logic [MW-1:0]    r_mat;
    logic             r_mat_stb;
    logic [RW-1:0]    r_row;
    logic [CLW-1:0]   r_col;
    logic [CW-1:0]    r_count;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_last;
    logic             w_slot_free;
    logic             w_load_in;
    logic             w_load_buf;
    logic [MW-1:0]    w_buf_shift;

    assign input_elem_ack = (r_state == S_FILLING);
    assign output_mat     = r_mat;
    assign output_mat_stb = r_mat_stb;
    assign fill_count     = r_count;

    assign w_in_xfer   = input_elem_stb & input_elem_ack;
    assign w_out_xfer  = r_mat_stb & output_mat_ack;
    assign w_last      = w_in_xfer & (r_row == RW'(M - 1)) & (r_col == CLW'(N - 1));
    assign w_slot_free = ~r_mat_stb | output_mat_ack;
    assign w_load_in   = w_last & w_slot_free;
    assign w_load_buf  = (r_state == S_FULL) & w_out_xfer;

    // Shifting in at the bottom leaves element 0 in the top slot after M*N arrivals.
    assign w_buf_shift = MW'({r_buf, input_elem});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FILLING;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILLING: if (w_last && !w_slot_free) w_state_nxt = S_FULL;
            S_FULL:    if (w_out_xfer)             w_state_nxt = S_FILLING;
            default:                               w_state_nxt = S_FILLING;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf     <= '0;
            r_mat     <= '0;
            r_mat_stb <= 1'b0;
            r_row     <= '0;
            r_col     <= '0;
            r_count   <= '0;
        end else begin
            if (w_in_xfer) begin
                r_buf <= w_buf_shift;
            end

            if (w_load_in) begin
                r_mat <= w_buf_shift;
            end else if (w_load_buf) begin
                r_mat <= r_buf;
            end

            if (w_load_in || w_load_buf) begin
                r_mat_stb <= 1'b1;
            end else if (w_out_xfer) begin
                r_mat_stb <= 1'b0;
            end

            // A completed matrix that cannot move out parks in the buffer, reported as full.
            if (w_last) begin
                r_row   <= '0;
                r_col   <= '0;
                r_count <= w_slot_free ? CW'(0) : CW'(TOTAL);
            end else if (w_in_xfer) begin
                r_count <= r_count + CW'(1);
                if (r_col == CLW'(N - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + RW'(1);
                end else begin
                    r_col <= r_col + CLW'(1);
                end
            end else if (w_load_buf) begin
                r_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mat_assemble.sv
// Directed bench for mat_assemble (M=2, N=3): vector table plus multi-cycle corner sequences.
module tb_mat_assemble;

    localparam int unsigned M  = 2;
    localparam int unsigned N  = 3;
    localparam int unsigned NV = 19;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [31:0]               input_elem;
    logic                      input_elem_stb;
    logic                      input_elem_ack;
    logic [M-1:0][N-1:0][31:0] output_mat;
    logic                      output_mat_stb;
    logic                      output_mat_ack;
    logic [2:0]                fill_count;

    mat_assemble #(.M(M), .N(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .input_elem     (input_elem),
        .input_elem_stb (input_elem_stb),
        .input_elem_ack (input_elem_ack),
        .output_mat     (output_mat),
        .output_mat_stb (output_mat_stb),
        .output_mat_ack (output_mat_ack),
        .fill_count     (fill_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         stb;
        logic [31:0]  elem;
        logic         ack;
        logic         exp_stb;
        logic         exp_iack;
        logic [2:0]   exp_cnt;
        logic         chk_mat;
        logic [191:0] exp_mat;
    } vec_t;

    vec_t vecs [NV];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] fl(input int i);
        case (i)
            1:  return 32'h3F800000;
            2:  return 32'h40000000;
            3:  return 32'h40400000;
            4:  return 32'h40800000;
            5:  return 32'h40A00000;
            6:  return 32'h40C00000;
            7:  return 32'h40E00000;
            8:  return 32'h41000000;
            9:  return 32'h41100000;
            10: return 32'h41200000;
            11: return 32'h41300000;
            12: return 32'h41400000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [191:0] mat6(input int a, input int b, input int c,
                                          input int d, input int e, input int f);
        return {fl(a), fl(b), fl(c), fl(d), fl(e), fl(f)};
    endfunction

    function automatic vec_t mk(input logic s, input logic [31:0] e, input logic a,
                                input logic es, input logic ei, input logic [2:0] ec,
                                input logic cm, input logic [191:0] em);
        vec_t v;
        v.stb = s; v.elem = e; v.ack = a;
        v.exp_stb = es; v.exp_iack = ei; v.exp_cnt = ec;
        v.chk_mat = cm; v.exp_mat = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic es, input logic ei, input logic [2:0] ec);
        chk({tag, " output_mat_stb"}, 192'(output_mat_stb), 192'(es));
        chk({tag, " input_elem_ack"}, 192'(input_elem_ack), 192'(ei));
        chk({tag, " fill_count"},     192'(fill_count),     192'(ec));
    endtask

    task automatic step(input logic s, input logic [31:0] e, input logic a);
        input_elem_stb = s;
        input_elem     = e;
        output_mat_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " output_mat"}, output_mat, 192'(0));
        chk_out(tag, 1'b0, 1'b1, 3'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int xfers;
        int stalls;
        logic [191:0] m_big;

        // Ack-always stream of 1..6, then a gapped producer feeding 6..1 with garbage in idle slots.
        for (int i = 0; i < 5; i++)
            vecs[i] = mk(1'b1, fl(i + 1), 1'b1, 1'b0, 1'b1, 3'(i + 1), 1'b0, 192'(0));
        vecs[5] = mk(1'b1, fl(6), 1'b1, 1'b1, 1'b1, 3'd0, 1'b1, mat6(1, 2, 3, 4, 5, 6));
        vecs[6] = mk(1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, mat6(1, 2, 3, 4, 5, 6));
        for (int j = 0; j < 5; j++) begin
            vecs[7 + 2*j] = mk(1'b1, fl(6 - j), 1'b1, 1'b0, 1'b1, 3'(j + 1), 1'b0, 192'(0));
            vecs[8 + 2*j] = mk(1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 3'(j + 1), 1'b0, 192'(0));
        end
        vecs[17] = mk(1'b1, fl(1), 1'b1, 1'b1, 1'b1, 3'd0, 1'b1, mat6(6, 5, 4, 3, 2, 1));
        vecs[18] = mk(1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, mat6(6, 5, 4, 3, 2, 1));

        rst = 1'b0;
        input_elem = 32'h0;
        input_elem_stb = 1'b0;
        output_mat_ack = 1'b0;
        #3;
        chk_reset("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].stb, vecs[i].elem, vecs[i].ack);
            chk_out($sformatf("vec%0d", i), vecs[i].exp_stb, vecs[i].exp_iack, vecs[i].exp_cnt);
            if (vecs[i].chk_mat)
                chk($sformatf("vec%0d output_mat", i), output_mat, vecs[i].exp_mat);
        end

        // Consumer stalled: second matrix parks in the fill buffer and blocks input.
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, fl(k), 1'b0);
            chk_out($sformatf("stall k%0d", k), k >= 6, k != 12, 3'((k < 6) ? k : k - 6));
            if (k >= 6)
                chk($sformatf("stall k%0d output_mat", k), output_mat, mat6(1, 2, 3, 4, 5, 6));
        end
        step(1'b1, 32'hBAADF00D, 1'b0);
        chk_out("stall hold", 1'b1, 1'b0, 3'd6);
        chk("stall hold output_mat", output_mat, mat6(1, 2, 3, 4, 5, 6));
        step(1'b1, 32'hBAADF00D, 1'b1);
        chk_out("stall release", 1'b1, 1'b1, 3'd0);
        chk("stall release output_mat", output_mat, mat6(7, 8, 9, 10, 11, 12));
        step(1'b0, 32'h0, 1'b0);
        chk_out("stall after", 1'b1, 1'b1, 3'd0);
        chk("stall after output_mat", output_mat, mat6(7, 8, 9, 10, 11, 12));
        step(1'b0, 32'h0, 1'b1);
        chk_out("stall drain", 1'b0, 1'b1, 3'd0);

        // Back-to-back stream of 18 elements with the consumer always ready.
        xfers = 0;
        stalls = 0;
        for (int k = 0; k < 18; k++) begin
            step(1'b1, 32'(k + 100), 1'b1);
            if (output_mat_stb) xfers++;
            if (!input_elem_ack) stalls++;
        end
        m_big = {32'd112, 32'd113, 32'd114, 32'd115, 32'd116, 32'd117};
        chk("stream last output_mat", output_mat, m_big);
        step(1'b0, 32'h0, 1'b1);
        if (output_mat_stb) xfers++;
        chk("stream transfers", 192'(xfers), 192'(3));
        chk("stream stalls", 192'(stalls), 192'(0));

        // Reset in the middle of a partial second matrix with a pending output.
        for (int k = 0; k < 6; k++) step(1'b1, 32'(32'h11 + k), 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 32'(32'h21 + k), 1'b0);
        chk_out("prerst", 1'b1, 1'b1, 3'd4);
        #2;
        rst = 1'b0;
        #1;
        chk_reset("midrst");
        @(posedge clk);
        #1;
        chk_reset("midrst held");
        rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, fl(k), 1'b1);
            if (k == 1) chk_out("postrst k1", 1'b0, 1'b1, 3'd1);
        end
        chk_out("postrst done", 1'b1, 1'b1, 3'd0);
        chk("postrst output_mat", output_mat, mat6(1, 2, 3, 4, 5, 6));
        step(1'b0, 32'h0, 1'b1);
        chk_out("postrst drain", 1'b0, 1'b1, 3'd0);

        // Last element lands on the same edge the previous matrix is acked.
        for (int k = 1; k <= 11; k++) step(1'b1, fl(k), 1'b0);
        chk_out("same-edge pre", 1'b1, 1'b1, 3'd5);
        chk("same-edge pre output_mat", output_mat, mat6(1, 2, 3, 4, 5, 6));
        step(1'b1, fl(12), 1'b1);
        chk_out("same-edge", 1'b1, 1'b1, 3'd0);
        chk("same-edge output_mat", output_mat, mat6(7, 8, 9, 10, 11, 12));
        step(1'b0, 32'h0, 1'b0);
        chk_out("same-edge hold", 1'b1, 1'b1, 3'd0);
        chk("same-edge hold output_mat", output_mat, mat6(7, 8, 9, 10, 11, 12));
        step(1'b0, 32'h0, 1'b1);
        chk_out("same-edge drain", 1'b0, 1'b1, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mat_assemble.md
MAT_ASSEMBLE -- requirements
Module: mat_assemble

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clk and rst, and rst=0 SHALL reset the block.
REQ-002 Parameter M, default 2: number of matrix rows (M>=1).
REQ-003 Parameter N, default 3: number of matrix columns (N>=1).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 input_elem  input  32  IEEE-754 single element; passed through bit-exact, never interpreted.
REQ-007 input_elem_stb  input  1  producer has a valid input_elem.
REQ-008 input_elem_ack  output  1  block can accept an element this cycle.
REQ-009 output_mat  output  M*N*32, packed [M-1:0][N-1:0][31:0]  assembled matrix.
REQ-010 output_mat_stb  output  1  output_mat valid.
REQ-011 output_mat_ack  input  1  consumer accepts output_mat.
REQ-012 fill_count  output  $clog2(M*N+1)  elements currently held in the fill buffer.

Function
REQ-013 An input transfer SHALL occur on a rising edge where input_elem_stb=1 and input_elem_ack=1; an output transfer SHALL occur on a rising edge where output_mat_stb=1 and output_mat_ack=1.
REQ-014 Elements SHALL be numbered k=0..M*N-1 in arrival order; element k SHALL be stored at [M-1-k/N][N-1-k%N], so that an MSB-first concatenation of the output in arrival order reproduces output_mat.
REQ-015 The block SHALL have two storage banks: a fill buffer plus row/column counters, and the output register output_mat.
REQ-016 On each input transfer, fill_count SHALL increment by 1; the column index SHALL wrap from N-1 to 0 and advance the row index.
REQ-017 On the input transfer of element M*N-1, if the output slot is free, the fill buffer contents including that element SHALL load into output_mat.
 - Output slot free: output_mat_stb=0, or an output transfer occurs on the same edge.
 - On that load: output_mat_stb=1 on the next cycle, and fill_count and the counters SHALL return to 0 on the same edge.
 - Latency: last element accepted -> output_mat_stb high, 1 cycle.
REQ-018 On the input transfer of element M*N-1, if the output slot is occupied and not being acked, the fill buffer SHALL be marked full and fill_count SHALL read M*N.
REQ-019 input_elem_ack SHALL be combinational: input_elem_ack = NOT fill_full.
REQ-020 While fill_full=1, an output transfer SHALL load the fill buffer into output_mat on that edge, keep output_mat_stb=1, clear fill_full, and zero fill_count.
REQ-021 An output transfer with fill_full=0 and no simultaneous completing input SHALL drive output_mat_stb=0 on the next cycle; output_mat SHALL retain its last value.
REQ-022 While output_mat_stb=1 and no output transfer occurs, output_mat SHALL be held bit-stable.
REQ-023 Simultaneous input and output transfers on one edge SHALL both take effect, with no element lost or duplicated.
REQ-024 Sustained throughput SHALL be one element per cycle when the consumer acks within M*N cycles of each output_mat_stb assertion.
REQ-025 input_elem SHALL be ignored whenever no input transfer occurs.
REQ-026 Implementation: a two-state fill FSM (FILLING, FULL) plus an output-valid flag; no arithmetic other than the counters.

Reset
REQ-027 While rst=0, outputs SHALL read: output_mat=0, output_mat_stb=0, fill_count=0, input_elem_ack=1.
REQ-028 While rst=0, the counters SHALL be 0 and the FSM SHALL be in FILLING.
REQ-029 Reset mid-matrix SHALL discard all partially filled and pending data; the next accepted element SHALL be k=0.

Verification
REQ-030 M=2,N=3, output_mat_ack=1; stream 3F800000,40000000,40400000,40800000,40A00000,40C00000 on consecutive cycles -> one cycle after the 6th accept, output_mat={3F800000,40000000,40400000,40800000,40A00000,40C00000}, output_mat_stb=1 for exactly one cycle.
REQ-031 output_mat_ack=0; stream 12 elements 1..12 (float) -> first matrix 1..6 held stable; input_elem_ack=0 after the 12th accept with fill_count=6; raising ack for one cycle -> output_mat becomes 7..12, stb remains 1, input_elem_ack returns to 1.
REQ-032 Continuous stb with ack=1, 18 elements -> exactly 3 output transfers, no stall cycle on input_elem_ack.
REQ-033 Gapped producer (stb toggling every cycle), values 6,5,4,3,2,1 -> output_mat={40C00000,40A00000,40800000,40400000,40000000,3F800000}; stb low cycles cause no count change.
REQ-034 Assert rst after 4 accepted elements -> all outputs at reset values; 6 new elements produce a matrix containing only the new values.
REQ-035 Element 6 accepted on the same edge output_mat_ack acks the previous matrix -> output_mat_stb stays 1 and output_mat updates to the new matrix with no gap cycle.
